// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, parity-mode constants
// and the parity helper used by the receiver's parity check.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  localparam int MAX_DATA_BITS = 9;

  // Expected parity bit; zero-extended payloads give the same result.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Sample-tick divider: one tick every CLKS_PER_TICK clk cycles, with a
// synchronous phase clear so a new frame starts on a fresh tick phase.
module uart_tick_gen #(
  parameter int CLKS_PER_TICK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_TICK - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Divider counter, wraps at CLKS_PER_TICK-1.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised oversampling UART receiver with a valid/ready output.
// Optional parity check is compiled in with macro UART_RX_PARITY_EN.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int CLKS_PER_TICK = 4,
  parameter int STOP_BITS     = 1,
  parameter int PARITY_ODD    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t DATA_EXIT = ST_PARITY;
`else
  localparam rx_state_t DATA_EXIT = ST_STOP;
`endif

  logic                     sync1_r, sync2_r, rx_s;
  rx_state_t                state_r, state_nx_s;
  logic [TICK_W-1:0]        tick_cnt_r, tick_cnt_nx_s, tick_cnt_inc_s;
  logic [3:0]               bit_cnt_r, bit_cnt_nx_s;
  logic [DATA_BITS-1:0]     shift_r, shift_nx_s;
  logic                     par_bad_r, par_bad_nx_s;
  logic [MAX_DATA_BITS-1:0] par_data_s;
  logic                     tick_s, tick_clear_s, half_due_s, bit_due_s;
  logic                     good_frame_s, frame_err_s, parity_err_s;
  logic [DATA_BITS-1:0]     m_data_r;
  logic                     m_valid_r, frame_err_r, parity_err_r, overrun_r, busy_r;

  uart_tick_gen #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear_s),
    .tick  (tick_s)
  );

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
    end
  end

  assign rx_s           = sync2_r;
  assign half_due_s     = tick_s && (tick_cnt_r == TICK_HALF);
  assign bit_due_s      = tick_s && (tick_cnt_r == TICK_FULL);
  assign tick_cnt_inc_s = tick_s ? (tick_cnt_r + TICK_ONE) : tick_cnt_r;

  // Next-state and datapath update for the receive FSM.
  always_comb begin
    state_nx_s    = state_r;
    tick_cnt_nx_s = tick_cnt_r;
    bit_cnt_nx_s  = bit_cnt_r;
    shift_nx_s    = shift_r;
    par_bad_nx_s  = par_bad_r;
    tick_clear_s  = 1'b0;
    good_frame_s  = 1'b0;
    frame_err_s   = 1'b0;
    parity_err_s  = 1'b0;
    par_data_s    = {MAX_DATA_BITS{1'b0}};
    par_data_s[DATA_BITS-1:0] = shift_r;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nx_s    = ST_START;
          tick_cnt_nx_s = {TICK_W{1'b0}};
          bit_cnt_nx_s  = 4'd0;
          par_bad_nx_s  = 1'b0;
          tick_clear_s  = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (half_due_s) begin
          tick_cnt_nx_s = {TICK_W{1'b0}};
          state_nx_s    = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          tick_cnt_nx_s = tick_cnt_inc_s;
        end
      end
      ST_DATA: begin
        if (bit_due_s) begin
          tick_cnt_nx_s = {TICK_W{1'b0}};
          shift_nx_s    = {rx_s, shift_r[DATA_BITS-1:1]};
          if (bit_cnt_r == DATA_LAST) begin
            bit_cnt_nx_s = 4'd0;
            state_nx_s   = DATA_EXIT;
          end else begin
            bit_cnt_nx_s = bit_cnt_r + 4'd1;
          end
        end else begin
          tick_cnt_nx_s = tick_cnt_inc_s;
        end
      end
      ST_PARITY: begin
        if (bit_due_s) begin
          tick_cnt_nx_s = {TICK_W{1'b0}};
          par_bad_nx_s  = (rx_s != parity_bit(par_data_s, PAR_MODE));
          state_nx_s    = ST_STOP;
        end else begin
          tick_cnt_nx_s = tick_cnt_inc_s;
        end
      end
      ST_STOP: begin
        if (bit_due_s) begin
          tick_cnt_nx_s = {TICK_W{1'b0}};
          if (!rx_s) begin
            frame_err_s = 1'b1;
            state_nx_s  = ST_BREAK;
          end else if (bit_cnt_r == STOP_LAST) begin
            state_nx_s   = ST_IDLE;
            good_frame_s = !par_bad_r;
`ifdef UART_RX_PARITY_EN
            parity_err_s = par_bad_r;
`else
            parity_err_s = 1'b0;
`endif
          end else begin
            bit_cnt_nx_s = bit_cnt_r + 4'd1;
          end
        end else begin
          tick_cnt_nx_s = tick_cnt_inc_s;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_BREAK;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= {TICK_W{1'b0}};
      bit_cnt_r  <= 4'd0;
      shift_r    <= {DATA_BITS{1'b0}};
      par_bad_r  <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      tick_cnt_r <= tick_cnt_nx_s;
      bit_cnt_r  <= bit_cnt_nx_s;
      shift_r    <= shift_nx_s;
      par_bad_r  <= par_bad_nx_s;
    end
  end

  // Output holding register and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_data_r     <= {DATA_BITS{1'b0}};
      m_valid_r    <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      frame_err_r  <= frame_err_s;
      parity_err_r <= parity_err_s;
      overrun_r    <= good_frame_s && m_valid_r && !m_ready;
      busy_r       <= (state_nx_s != ST_IDLE);
      // A handshake in the completion cycle frees the slot for the new frame.
      if (good_frame_s && (!m_valid_r || m_ready)) begin
        m_data_r  <= shift_r;
        m_valid_r <= 1'b1;
      end else if (m_valid_r && m_ready) begin
        m_valid_r <= 1'b0;
      end else begin
        m_valid_r <= m_valid_r;
      end
    end
  end

  assign m_data     = m_data_r;
  assign m_valid    = m_valid_r;
  assign frame_err  = frame_err_r;
  assign parity_err = parity_err_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, payload bits per frame, legal range 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit period, even, minimum 8.
REQ-003 SHALL have parameter CLKS_PER_TICK, default 4, clk cycles per sample tick, minimum 1.
REQ-004 SHALL have parameter STOP_BITS, default 1, number of stop bits checked, 1 or 2.
REQ-005 SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity (used only with parity compiled in).
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port m_data, output, DATA_BITS, received payload, LSB first on the line.
REQ-010 SHALL have port m_valid, output, 1, m_data holds an unconsumed frame.
REQ-011 SHALL have port m_ready, input, 1, consumer accepts m_data.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-013 SHALL have port parity_err, output, 1, one-cycle pulse on a parity mismatch (tied 0 when parity is compiled out).
REQ-014 SHALL have port overrun, output, 1, one-cycle pulse when a good frame is dropped.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-018 SHALL, in IDLE, enter START when synchronized rx is 0, and restart the tick phase and tick count at that moment.
REQ-019 SHALL sample synchronized rx in START after OVERSAMPLE/2 ticks: 0 -> DATA; 1 -> IDLE with no error pulse (glitch rejected).
REQ-020 SHALL, in DATA, sample every OVERSAMPLE ticks from the start-bit sample point, shift the bits in LSB first, and leave after DATA_BITS samples for PARITY (parity compiled in) or STOP.
REQ-021 SHALL, in PARITY, sample one bit and compare it with XOR(payload) XOR PARITY_ODD; a mismatch marks the frame bad.
REQ-022 SHALL, in STOP, sample STOP_BITS bits; any 0 pulses frame_err, drops the frame, and goes to BREAK.
REQ-023 SHALL, in BREAK, wait for synchronized rx to be 1, then go to IDLE.
REQ-024 SHALL pulse parity_err, not frame_err, for a frame whose parity is bad and whose stop bits are good, drop that frame, and go to IDLE.
REQ-025 SHALL, on a good frame, load m_data and assert m_valid in the cycle after the last stop-bit sample.
REQ-026 SHALL hold m_valid and m_data stable until a cycle with m_valid and m_ready both high; m_valid clears after that cycle.
REQ-027 SHALL, if a good frame completes while m_valid=1 and m_ready=0, keep the old m_data, drop the new frame, and pulse overrun.
REQ-028 SHALL, if a good frame completes in the same cycle as a handshake, load the new frame with m_valid staying 1 and no overrun.
REQ-029 SHALL never make m_valid depend combinationally on m_ready.

Reset
REQ-030 SHALL, on reset, set state to IDLE, zero the tick divider and all counters, set the synchronizer flops to 1, m_data=0, m_valid=0, and frame_err=parity_err=overrun=busy=0.
REQ-031 SHALL, on reset mid-frame, abandon the partial frame without an error pulse and need a fresh falling edge to start again.

Configuration
REQ-032 SHALL, with macro UART_RX_PARITY_EN defined, include the PARITY state and check one parity bit between the data and stop bits.
REQ-033 SHALL, without UART_RX_PARITY_EN, go straight from DATA to STOP, tie parity_err to 0, and ignore PARITY_ODD.

Structure
REQ-034 SHALL take its state enum and parity-mode constants from shared package uart_pkg.
REQ-035 SHALL generate the sample tick in sub-module uart_tick_gen (a CLKS_PER_TICK divider with a synchronous phase clear).

Verification (OVERSAMPLE=16, CLKS_PER_TICK=1, DATA_BITS=8, STOP_BITS=1 unless stated)
REQ-036 SHALL test: frame 0xA5 sent while m_ready=0 for 50 cycles -> m_valid=1 and m_data=0xA5 held, cleared one cycle after m_ready=1.
REQ-037 SHALL test: rx low for 4 ticks, then high -> no m_valid, no error, busy back to 0 within 9 ticks.
REQ-038 SHALL test: frame 0x3C with stop bit 0, then rx held low for 40 ticks -> frame_err pulses once, no m_valid, and next frame 0x55 is received correctly.
REQ-039 SHALL test: frames 0x11 then 0x22 back to back with m_ready=0 -> m_data=0x11 and one overrun pulse; repeated with m_ready=1 on the 0x22 completion cycle -> m_data=0x22 and no overrun.
REQ-040 SHALL test: UART_RX_PARITY_EN defined, PARITY_ODD=1, frame 0x07 with parity bit 1 -> parity_err pulse and no m_valid; same frame with parity bit 0 -> m_valid with 0x07.
REQ-041 SHALL test: reset asserted during data bit 4 of 0xF0 -> all outputs 0 next cycle, and no m_valid until the next start bit.
